// File: rtl/timed_memory.sv
// ============================================================================
// Module   : timed_memory
// Brief    : Behavioural RAM model with fixed programmable access latency,
//            byte-lane write masking, request latching and range checking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module timed_memory #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 16,
  parameter int LATENCY    = 12,
  parameter     INIT_FILE  = ""
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W/8-1:0] wmask,
  input  logic [31:0]         address,
  input  logic [DATA_W-1:0]   wdata,
  output logic                resp,
  output logic [DATA_W-1:0]   rdata,
  output logic                err,
  output logic                busy
);

  localparam int LANES = DATA_W / 8;
  localparam int B     = $clog2(LANES);
  localparam int TOP   = DEPTH_LOG2 + B;
  localparam logic [7:0] LAST_WAIT = 8'(LATENCY - 2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    ACCESS  = 2'd2,
    RESPOND = 2'd3
  } state_t;

  state_t                  state;
  logic [7:0]              count;
  logic                    req_read;
  logic                    req_write;
  logic                    req_oor;
  logic [LANES-1:0]        req_mask;
  logic [DEPTH_LOG2-1:0]   req_index;
  logic [DATA_W-1:0]       req_wdata;
  logic                    addr_oor;
  logic [DATA_W-1:0]       merged;
  logic                    unused_addr;

  logic [DATA_W-1:0] mem [0:(2**DEPTH_LOG2)-1];

  // Any address bit above the word index makes the access out of range.
  generate
    if (TOP < 32) begin : g_range
      assign addr_oor = |address[31:TOP];
    end else begin : g_full
      assign addr_oor = 1'b0;
    end
  endgenerate

  // Low lane-select bits are deliberately ignored.
  assign unused_addr = ^address;

  assign busy = (state != IDLE);

  // Post-write word: serves as the write value and as the read-back value,
  // so a combined read+write returns the merged result.
  always_comb begin
    merged = mem[req_index];
    for (int i = 0; i < LANES; i++) begin
      if (req_write && req_mask[i]) begin
        merged[8*i +: 8] = req_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == ACCESS && req_write && !req_oor) begin
      mem[req_index] <= merged;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= 8'd0;
      resp      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      req_read  <= 1'b0;
      req_write <= 1'b0;
      req_oor   <= 1'b0;
      req_mask  <= '0;
      req_index <= '0;
      req_wdata <= '0;
    end else begin
      resp <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (read || write) begin
            req_read  <= read;
            req_write <= write;
            req_oor   <= addr_oor;
            req_mask  <= wmask;
            req_index <= address[TOP-1:B];
            req_wdata <= wdata;
            count     <= 8'd1;
            state     <= (LATENCY == 2) ? ACCESS : WAIT;
          end
        end
        WAIT: begin
          count <= count + 8'd1;
          if (count == LAST_WAIT) begin
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (req_oor) begin
            rdata <= '0;
          end else if (req_read) begin
            rdata <= merged;
          end
          resp  <= 1'b1;
          err   <= req_oor;
          state <= RESPOND;
        end
        RESPOND: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_timed_memory.sv
// ============================================================================
// Module   : tb_timed_memory
// Brief    : Randomised self-checking bench for timed_memory against a
//            word-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timed_memory;

  localparam int LAT = 5;
  localparam int DL  = 6;
  localparam int DW  = 32;
  localparam int WORDS = 2**DL;

  logic        clk = 1'b0;
  logic        rst;
  logic        read;
  logic        write;
  logic [3:0]  wmask;
  logic [31:0] address;
  logic [31:0] wdata;
  logic        resp;
  logic [31:0] rdata;
  logic        err;
  logic        busy;

  always #5 clk = ~clk;

  timed_memory #(
    .DATA_W    (DW),
    .DEPTH_LOG2(DL),
    .LATENCY   (LAT),
    .INIT_FILE ("")
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .read   (read),
    .write  (write),
    .wmask  (wmask),
    .address(address),
    .wdata  (wdata),
    .resp   (resp),
    .rdata  (rdata),
    .err    (err),
    .busy   (busy)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model [WORDS];
  logic [31:0] exp_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after resp.
  task automatic request(input bit rd, input bit wr, input logic [3:0] m,
                         input logic [31:0] a, input logic [31:0] d);
    int k;
    bit busy_ok;
    bit oor;
    int idx;
    read = rd; write = wr; wmask = m; address = a; wdata = d;
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    oor = (a[31:DL+2] != 0);
    idx = int'(a[DL+1:2]);
    if (oor) begin
      exp_rdata = 32'h0;
    end else begin
      if (wr) begin
        for (int i = 0; i < 4; i++) begin
          if (m[i]) model[idx][8*i +: 8] = d[8*i +: 8];
        end
      end
      if (rd) exp_rdata = model[idx];
    end
    k = 1;
    busy_ok = 1'b1;
    while (resp !== 1'b1 && k < 4*LAT) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      address = $urandom; wdata = $urandom; wmask = 4'($urandom);
      @(negedge clk);
      k++;
    end
    if (busy !== 1'b1) busy_ok = 1'b0;
    check("latency", k, LAT);
    check("busy_during", {31'd0, busy_ok}, 32'd1);
    check("err", {31'd0, err}, {31'd0, oor});
    check("rdata", rdata, exp_rdata);
    @(negedge clk);
    check("after_resp_resp_busy", {30'd0, resp, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] old_word;
    bit          saw_resp;
    bit          rd;
    bit          wr;

    rst = 1'b1; read = 1'b0; write = 1'b0; wmask = 4'h0; address = 32'h0; wdata = 32'h0;
    exp_rdata = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_resp", {31'd0, resp}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_rdata", rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < WORDS; i++) begin
      request(1'b0, 1'b1, 4'hF, 32'(i*4), $urandom);
    end

    request(1'b0, 1'b1, 4'hF, 32'h10, 32'hFFFF_FFFF);
    request(1'b0, 1'b1, 4'b0101, 32'h10, 32'h1122_3344);
    request(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    check("masked_write_literal", rdata, 32'hFF22_FF44);

    request(1'b1, 1'b1, 4'hF, 32'h20, 32'hCAFE_F00D);
    check("read_write_literal", rdata, 32'hCAFE_F00D);

    request(1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
    check("oor_read_literal", rdata, 32'h0);
    request(1'b0, 1'b1, 4'hF, 32'h100, 32'h5A5A_5A5A);
    request(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);

    request(1'b0, 1'b1, 4'h0, 32'h30, 32'h1234_5678);
    request(1'b1, 1'b0, 4'h0, 32'h33, 32'h0);

    // Write aborted by reset during the third WAIT cycle.
    old_word = model[2];
    read = 1'b0; write = 1'b1; wmask = 4'hF; address = 32'h8; wdata = ~old_word;
    @(negedge clk);
    write = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_rdata", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    saw_resp = 1'b0;
    repeat (LAT + 3) begin
      if (resp === 1'b1) saw_resp = 1'b1;
      @(negedge clk);
    end
    check("abort_no_resp", {31'd0, saw_resp}, 32'd0);
    exp_rdata = 32'h0;
    request(1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
    check("abort_old_contents", rdata, old_word);

    for (int n = 0; n < 40; n++) begin
      rd = 1'($urandom);
      wr = rd ? 1'($urandom) : 1'b1;
      request(rd, wr, 4'($urandom),
              ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFF),
              $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
